head_detect_seq: RTL and testbench



---
 rtl/head_detect_seq.sv | 132 +++++++++++++
 tb/tb_head_detect_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_detect_seq.sv
// head_detect_seq: sequential, flow-controlled leading/trailing-one detector.
// A word is scanned CHUNK bits per cycle from the selected end. The result is
// the number of zeros before the first 1, or WIDTH with found_out=0 when the
// word holds no 1 at all.
module head_detect_seq #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int POS_W  = $clog2(WIDTH + 1),
  parameter int NCHUNK = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] pos_out,
  output logic             found_out
);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("head_detect_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  // Base position of the final chunk; reaching it without a hit means all zeros.
  localparam logic [POS_W-1:0] LAST_BASE = POS_W'((NCHUNK - 1) * CHUNK);
  localparam logic [POS_W-1:0] CHUNK_P   = POS_W'(CHUNK);
  localparam logic [POS_W-1:0] WIDTH_P   = POS_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;    // remaining bits, search end at bit 0
  logic [POS_W-1:0]   base_q, base_d;    // k*CHUNK of the chunk being examined
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               found_q, found_d;
  logic               hit_s;
  logic [POS_W-1:0]   off_s;

  // Reverse a word so MSB-first searching becomes LSB-first searching.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Offset of the lowest set bit in the current chunk (lowest index wins).
  always_comb begin
    off_s = '0;
    hit_s = |word_q[CHUNK-1:0];
    for (int j = CHUNK - 1; j >= 0; j--) begin
      off_s = word_q[j] ? POS_W'(j) : off_s;
    end
  end

  // Next-state and datapath update for the IDLE / SCAN / DONE sequence.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    base_d  = base_q;
    pos_d   = pos_q;
    found_d = found_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Mode is folded into the captured word, so later mode_in changes are inert.
          word_d  = mode_in ? data_in : bit_rev(data_in);
          base_d  = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          pos_d   = base_q + off_s;
          found_d = 1'b1;
          state_d = ST_DONE;
        end else if (base_q == LAST_BASE) begin
          pos_d   = WIDTH_P;
          found_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          word_d  = word_q >> CHUNK;
          base_d  = base_q + CHUNK_P;
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      base_q  <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      base_q  <= base_d;
      pos_q   <= pos_d;
      found_q <= found_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign pos_out   = pos_q;
  assign found_out = found_q;

endmodule

// File: tb/tb_head_detect_seq.sv
// Self-checking bench for head_detect_seq: directed cases on a 32/8 instance
// plus randomised scoreboard runs on several WIDTH/CHUNK combinations.
module tb_head_detect_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int pos;
    int fnd;
    int lat;
    int acc;
  } exp_t;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: zeros before the first 1 counted from the selected end.
  function automatic int ref_pos(input logic [31:0] d, input logic m, input int w);
    for (int i = 0; i < w; i++) begin
      if (d[m ? i : w - 1 - i]) return i;
    end
    return w;
  endfunction

  // ---------------- directed instance (32, 8) ----------------
  logic        rst_n;
  logic        d_rst_n, d_iv, d_ir, d_md, d_ov, d_ordy, d_fnd;
  logic [31:0] d_din;
  logic [5:0]  d_pos;
  exp_t        dq[$];
  exp_t        d_e;
  bit          d_rep = 1'b0;

  head_detect_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_ready(d_ir),
    .data_in(d_din), .mode_in(d_md), .out_valid(d_ov), .out_ready(d_ordy),
    .pos_out(d_pos), .found_out(d_fnd)
  );

  // Directed monitor: each new result is popped and compared once.
  always @(negedge clk) begin
    if (d_rst_n && d_ov && !d_rep) begin
      if (dq.size() == 0) begin
        chk_eq("dir_unexpected_result", 1, 0);
      end else begin
        d_e = dq.pop_front();
        chk_eq("dir_pos", int'(d_pos), d_e.pos);
        chk_eq("dir_found", int'(d_fnd), d_e.fnd);
        chk_eq("dir_latency", cyc - d_e.acc, d_e.lat);
      end
    end
    d_rep <= d_ov & ~d_ordy;
  end

  task automatic d_wait_ready();
    int n = 0;
    while (!d_ir && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("dir_in_ready_wait", int'(d_ir), 1);
  endtask

  task automatic d_send(input logic [31:0] d, input logic m, input int p,
                        input int f, input int lat);
    exp_t x;
    d_wait_ready();
    d_din = d; d_md = m; d_iv = 1'b1;
    x.pos = p; x.fnd = f; x.lat = lat; x.acc = cyc + 1;
    dq.push_back(x);
    @(posedge clk); #1;
    d_iv = 1'b0; d_md = ~m; d_din = ~d;
  endtask

  task automatic d_wait_valid();
    int n = 0;
    @(negedge clk);
    while (!d_ov && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("dir_out_valid_wait", int'(d_ov), 1);
  endtask

  task automatic d_drain();
    int n = 0;
    while ((dq.size() != 0 || !d_ir) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("dir_drain", dq.size(), 0);
  endtask

  // ---------------- random instances ----------------
  localparam int NWORDS = 60;

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W  = (g == 0) ? 32 : (g == 1) ? 32 : (g == 2) ? 20 : 8;
    localparam int C  = (g == 0) ? 8  : (g == 1) ? 32 : (g == 2) ? 4  : 1;
    localparam int PW = $clog2(W + 1);
    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - W);

    logic          iv = 1'b0, md = 1'b0, ordy = 1'b0;
    logic          ir, ov, fnd;
    logic [W-1:0]  din = '0;
    logic [PW-1:0] pos;
    exp_t          q[$];
    exp_t          e;
    bit            rep = 1'b0;
    bit            done = 1'b0;
    int            n_out = 0;

    head_detect_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .data_in(din), .mode_in(md), .out_valid(ov), .out_ready(ordy),
      .pos_out(pos), .found_out(fnd)
    );

    // Random consumer back-pressure.
    initial begin
      forever begin
        @(posedge clk); #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    // Monitor: compare each new result against the scoreboard head.
    always @(negedge clk) begin
      if (rst_n && ov && !rep) begin
        n_out <= n_out + 1;
        if (q.size() == 0) begin
          chk_eq($sformatf("rnd%0d_unexpected_result", g), 1, 0);
        end else begin
          e = q.pop_front();
          chk_eq($sformatf("rnd%0d_pos", g), int'(pos), e.pos);
          chk_eq($sformatf("rnd%0d_found", g), int'(fnd), e.fnd);
          chk_eq($sformatf("rnd%0d_latency", g), cyc - e.acc, e.lat);
        end
      end
      rep <= ov & ~ordy;
    end

    // Driver: random words and modes, expected results pushed on accept.
    initial begin : drv
      logic [31:0] dw;
      exp_t        x;
      int          n;
      @(posedge rst_n);
      @(posedge clk); #1;
      for (int i = 0; i < NWORDS; i++) begin
        n = 0;
        while (!ir && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        if (!ir) chk_eq($sformatf("rnd%0d_ready_timeout", g), 0, 1);
        case ($urandom_range(0, 3))
          0:       dw = 32'h0;
          1:       dw = 32'h1 << $urandom_range(0, W - 1);
          default: dw = $urandom & $urandom;
        endcase
        dw = dw & MASK;
        md = 1'($urandom_range(0, 1));
        x.pos = ref_pos(dw, md, W);
        x.fnd = (x.pos < W) ? 1 : 0;
        x.lat = (x.pos < W) ? (x.pos / C + 1) : (W / C);
        x.acc = cyc + 1;
        q.push_back(x);
        din = W'(dw);
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0; md = ~md; din = ~din;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      n = 0;
      while ((q.size() != 0 || !ir) && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      chk_eq($sformatf("rnd%0d_drain", g), q.size(), 0);
      chk_eq($sformatf("rnd%0d_result_count", g), n_out, NWORDS);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; d_rst_n = 1'b0;
    d_iv = 1'b0; d_md = 1'b0; d_din = 32'h0; d_ordy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", int'(d_ir), 1);
    chk_eq("rst_out_valid", int'(d_ov), 0);
    chk_eq("rst_pos", int'(d_pos), 0);
    chk_eq("rst_found", int'(d_fnd), 0);
    @(posedge clk); #1;
    d_rst_n = 1'b1; rst_n = 1'b1;

    // MSB set: one-cycle result, in_ready back the cycle after handshake.
    d_send(32'h8000_0000, 1'b0, 0, 1, 1);
    d_wait_valid();
    chk_eq("t1_in_ready_busy", int'(d_ir), 0);
    @(negedge clk);
    chk_eq("t1_in_ready_after", int'(d_ir), 1);
    chk_eq("t1_out_valid_after", int'(d_ov), 0);
    @(posedge clk); #1;

    // Position and latency in both scan directions, and all-zero words.
    d_send(32'h0000_0001, 1'b0, 31, 1, 4);
    d_send(32'h0000_0001, 1'b1, 0,  1, 1);
    d_send(32'h0001_0000, 1'b0, 15, 1, 2);
    d_send(32'h0001_0000, 1'b1, 16, 1, 3);
    d_send(32'h0000_0000, 1'b0, 32, 0, 4);
    d_send(32'h0000_0000, 1'b1, 32, 0, 4);
    d_drain();

    // Back-pressure: result held, input ignored while DONE.
    d_ordy = 1'b0;
    d_send(32'h0400_0000, 1'b0, 5, 1, 1);
    d_wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_out_valid", int'(d_ov), 1);
      chk_eq("bp_pos", int'(d_pos), 5);
      chk_eq("bp_found", int'(d_fnd), 1);
      chk_eq("bp_in_ready", int'(d_ir), 0);
      @(posedge clk); #1;
      d_iv = (i % 2 == 0); d_din = 32'h0000_0001;
      @(negedge clk);
    end
    @(posedge clk); #1;
    d_iv = 1'b0; d_ordy = 1'b1;
    @(negedge clk);
    chk_eq("bp_held_before_hs", int'(d_ov), 1);
    @(negedge clk);
    chk_eq("bp_in_ready_after_hs", int'(d_ir), 1);
    chk_eq("bp_out_valid_after_hs", int'(d_ov), 0);
    @(posedge clk); #1;

    // Reset in the middle of a scan discards the word.
    d_wait_ready();
    d_din = 32'h0000_0100; d_md = 1'b0; d_iv = 1'b1;
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(posedge clk); #1;
    d_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_eq("mid_rst_out_valid", int'(d_ov), 0);
    chk_eq("mid_rst_in_ready", int'(d_ir), 1);
    chk_eq("mid_rst_pos", int'(d_pos), 0);
    chk_eq("mid_rst_found", int'(d_fnd), 0);
    @(posedge clk); #1;
    d_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_eq("mid_rst_no_result", int'(d_ov), 0);
    end

    // Wait for the random runs to finish.
    n = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done)
           && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk_eq("rnd_all_done",
           int'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
